// File: rtl/lt_sequencer_if.sv
// Control/status bundle between the host register block, the video
// generator, the photo-sensor and the latency-test sequencer.
// The master side drives requests, vsync and the sensor; the slave side
// (the sequencer) drives the patch control and measurement status.
interface lt_sequencer_if #(
    parameter int CNT_WIDTH = 24
);
    logic                 start;
    logic                 abort;
    logic [1:0]           mode_sel;
    logic                 vsync_in;
    logic                 sensor_n;
    logic                 lt_active;
    logic [1:0]           lt_mode;
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] latency;
    logic                 timeout;
    logic                 sensor_err;

    modport master (
        output start, abort, mode_sel, vsync_in, sensor_n,
        input  lt_active, lt_mode, busy, done, latency, timeout, sensor_err
    );

    modport slave (
        input  start, abort, mode_sel, vsync_in, sensor_n,
        output lt_active, lt_mode, busy, done, latency, timeout, sensor_err
    );
endinterface

// File: rtl/lt_sequencer.sv
// Latency-test sequencer: arms on request, turns the white patch on at the
// next frame start, counts clk27 cycles until the photo-sensor sees light
// (or a timeout expires), reports the result and then keeps the patch off
// for a cooldown of several frames before accepting another request.
module lt_sequencer #(
    parameter int                   CNT_WIDTH       = 24,
    parameter logic [CNT_WIDTH-1:0] TIMEOUT_CYCLES  = 24'd2700000,
    parameter logic [3:0]           COOLDOWN_FRAMES = 4'd4
) (
    input  logic        clk27,
    input  logic        reset_n,
    lt_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_FLASH,
        ST_RELEASE
    } state_t;

    // Last FLASH count value before the run is declared a timeout.
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1'b1);

    state_t               state_reg, state_next;
    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
    logic [3:0]           fcnt_reg, fcnt_next;
    logic                 lt_active_reg, lt_active_next;
    logic [1:0]           lt_mode_reg, lt_mode_next;
    logic                 busy_reg, busy_next;
    logic                 done_reg, done_next;
    logic [CNT_WIDTH-1:0] latency_reg, latency_next;
    logic                 timeout_reg, timeout_next;
    logic                 sensor_err_reg, sensor_err_next;

    logic                 sync1_reg;
    logic                 sensor_s_reg;
    logic                 vsync_d_reg;
    logic                 fs;

    // Two-flop synchroniser for the asynchronous sensor; idles dark (1).
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg    <= 1'b1;
            sensor_s_reg <= 1'b1;
        end else begin
            sync1_reg    <= bus.sensor_n;
            sensor_s_reg <= sync1_reg;
        end
    end

    // Delayed vsync used to find the falling (frame start) edge.
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            vsync_d_reg <= 1'b0;
        end else begin
            vsync_d_reg <= bus.vsync_in;
        end
    end

    // Frame start: vsync was high last cycle and is low now.
    assign fs = vsync_d_reg & ~bus.vsync_in;

    // FSM state register.
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath and output registers, all loaded from the next-state logic.
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg        <= '0;
            fcnt_reg       <= '0;
            lt_active_reg  <= 1'b0;
            lt_mode_reg    <= 2'b00;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            latency_reg    <= '0;
            timeout_reg    <= 1'b0;
            sensor_err_reg <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            fcnt_reg       <= fcnt_next;
            lt_active_reg  <= lt_active_next;
            lt_mode_reg    <= lt_mode_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            latency_reg    <= latency_next;
            timeout_reg    <= timeout_next;
            sensor_err_reg <= sensor_err_next;
        end
    end

    // Next-state and next-output logic; abort overrides everything else.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        fcnt_next       = fcnt_reg;
        lt_active_next  = lt_active_reg;
        lt_mode_next    = lt_mode_reg;
        done_next       = 1'b0;
        latency_next    = latency_reg;
        timeout_next    = timeout_reg;
        sensor_err_next = sensor_err_reg;

        if (bus.abort) begin
            // Silent return to idle: results and sticky flags are kept.
            state_next     = ST_IDLE;
            lt_active_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    lt_active_next = 1'b0;
                    if (bus.start) begin
                        if (sensor_s_reg) begin
                            lt_mode_next    = bus.mode_sel;
                            timeout_next    = 1'b0;
                            sensor_err_next = 1'b0;
                            state_next      = ST_ARM;
                        end else begin
                            // Sensor already lit: the measurement would be
                            // meaningless, so report an error and stay idle.
                            sensor_err_next = 1'b1;
                            done_next       = 1'b1;
                        end
                    end
                end

                ST_ARM: begin
                    if (fs) begin
                        lt_active_next = 1'b1;
                        cnt_next       = '0;
                        state_next     = ST_FLASH;
                    end
                end

                ST_FLASH: begin
                    // Saturate so a huge timeout never wraps the count.
                    if (cnt_reg != '1) begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                    // Light detection takes precedence over the timeout.
                    if (!sensor_s_reg) begin
                        latency_next   = cnt_reg;
                        lt_active_next = 1'b0;
                        fcnt_next      = '0;
                        state_next     = ST_RELEASE;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        timeout_next   = 1'b1;
                        lt_active_next = 1'b0;
                        fcnt_next      = '0;
                        state_next     = ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    if (fs && (fcnt_reg != COOLDOWN_FRAMES)) begin
                        fcnt_next = fcnt_reg + 1'b1;
                    end
                    // Do not finish while the sensor still sees light, so
                    // the next run cannot start against a lit display.
                    if ((fcnt_reg == COOLDOWN_FRAMES) && sensor_s_reg) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end

                default: begin
                    state_next     = ST_IDLE;
                    lt_active_next = 1'b0;
                end
            endcase
        end

        busy_next = (state_next != ST_IDLE);
    end

    assign bus.lt_active  = lt_active_reg;
    assign bus.lt_mode    = lt_mode_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.latency    = latency_reg;
    assign bus.timeout    = timeout_reg;
    assign bus.sensor_err = sensor_err_reg;

endmodule

// File: tb/tb_lt_sequencer.sv
// Directed bench for lt_sequencer with a short timeout (1000 cycles) and a
// two-frame cooldown. Inputs change 1 ns after a rising edge and outputs
// are checked at that same point, so each check sees the result of the
// edge just passed.
module tb_lt_sequencer;

    logic clk27   = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    always #5 clk27 = ~clk27;

    lt_sequencer_if #(.CNT_WIDTH(24)) bus ();

    lt_sequencer #(
        .CNT_WIDTH      (24),
        .TIMEOUT_CYCLES (24'd1000),
        .COOLDOWN_FRAMES(4'd2)
    ) dut (
        .clk27  (clk27),
        .reset_n(reset_n),
        .bus    (bus)
    );

    task automatic tick;
        @(posedge clk27);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic act, input logic [1:0] mode,
                             input logic busy, input logic done, input logic [23:0] lat,
                             input logic to, input logic serr);
        check({tag, ".lt_active"},  32'(bus.lt_active),  32'(act));
        check({tag, ".lt_mode"},    32'(bus.lt_mode),    32'(mode));
        check({tag, ".busy"},       32'(bus.busy),       32'(busy));
        check({tag, ".done"},       32'(bus.done),       32'(done));
        check({tag, ".latency"},    32'(bus.latency),    32'(lat));
        check({tag, ".timeout"},    32'(bus.timeout),    32'(to));
        check({tag, ".sensor_err"}, 32'(bus.sensor_err), 32'(serr));
    endtask

    // One-cycle low pulse on vsync; returns just after the edge that acted on it.
    task automatic pulse_vsync;
        bus.vsync_in = 1'b0;
        tick();
        bus.vsync_in = 1'b1;
    endtask

    task automatic do_start(input logic [1:0] mode);
        bus.mode_sel = mode;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.mode_sel = 2'b00;
        bus.vsync_in = 1'b1;
        bus.sensor_n = 1'b1;

        // Reset state, both during and just after reset.
        #12;
        check_all("reset", 0, 2'd0, 0, 0, 24'd0, 0, 0);
        reset_n = 1'b1;
        tick();
        tick();
        check_all("idle", 0, 2'd0, 0, 0, 24'd0, 0, 0);

        // 1: basic run; sensor drops 498 cycles after the first FLASH edge,
        // plus 2 synchroniser cycles gives a latency of 500.
        do_start(2'd2);
        check_all("t1.arm", 0, 2'd2, 1, 0, 24'd0, 0, 0);
        repeat (3) tick();
        check("t1.arm_wait", 32'(bus.lt_active), 32'd0);
        pulse_vsync();
        check("t1.flash_on", 32'(bus.lt_active), 32'd1);
        repeat (498) tick();
        bus.sensor_n = 1'b0;
        tick();
        tick();
        check("t1.still_on", 32'(bus.lt_active), 32'd1);
        tick();
        check_all("t1.detect", 0, 2'd2, 1, 0, 24'd500, 0, 0);
        bus.sensor_n = 1'b1;
        repeat (3) tick();
        pulse_vsync();
        tick();
        pulse_vsync();
        check("t1.cool_done0", 32'(bus.done), 32'd0);
        tick();
        check_all("t1.done", 0, 2'd2, 0, 1, 24'd500, 0, 0);
        tick();
        check_all("t1.after", 0, 2'd2, 0, 0, 24'd500, 0, 0);

        // 2: no sensor; patch stays on for exactly 1000 cycles.
        do_start(2'd1);
        check_all("t2.arm", 0, 2'd1, 1, 0, 24'd500, 0, 0);
        pulse_vsync();
        repeat (999) tick();
        check_all("t2.last", 1, 2'd1, 1, 0, 24'd500, 0, 0);
        tick();
        check_all("t2.timeout", 0, 2'd1, 1, 0, 24'd500, 1, 0);
        pulse_vsync();
        tick();
        pulse_vsync();
        check("t2.cool_done0", 32'(bus.done), 32'd0);
        tick();
        check_all("t2.done", 0, 2'd1, 0, 1, 24'd500, 1, 0);

        // 3: sensor lit at start; rejected, timeout flag from run 2 survives.
        bus.sensor_n = 1'b0;
        tick();
        tick();
        do_start(2'd3);
        check_all("t3.err", 0, 2'd1, 0, 1, 24'd500, 1, 1);
        tick();
        check_all("t3.after", 0, 2'd1, 0, 0, 24'd500, 1, 1);
        bus.sensor_n = 1'b1;
        tick();
        tick();

        // 4: abort at cnt=200; silent return to idle.
        do_start(2'd3);
        check_all("t4.arm", 0, 2'd3, 1, 0, 24'd500, 0, 0);
        pulse_vsync();
        repeat (200) tick();
        check("t4.flash", 32'(bus.lt_active), 32'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_all("t4.abort", 0, 2'd3, 0, 0, 24'd500, 0, 0);
        tick();
        check("t4.no_done", 32'(bus.done), 32'd0);
        pulse_vsync();
        tick();
        check("t4.idle_vsync", 32'(bus.lt_active), 32'd0);
        // abort beats start
        bus.abort = 1'b1;
        do_start(2'd0);
        bus.abort = 1'b0;
        check_all("t4.abort_start", 0, 2'd3, 0, 0, 24'd500, 0, 0);

        // 5: sensor stuck lit through cooldown; done waits for it to clear.
        do_start(2'd0);
        pulse_vsync();
        bus.sensor_n = 1'b0;
        tick();
        tick();
        check("t5.on", 32'(bus.lt_active), 32'd1);
        tick();
        check_all("t5.detect", 0, 2'd0, 1, 0, 24'd2, 0, 0);
        pulse_vsync();
        tick();
        pulse_vsync();
        repeat (20) tick();
        check("t5.stuck_done", 32'(bus.done), 32'd0);
        check("t5.stuck_busy", 32'(bus.busy), 32'd1);
        bus.sensor_n = 1'b1;
        tick();
        check("t5.clr1", 32'(bus.done), 32'd0);
        tick();
        check("t5.clr2", 32'(bus.done), 32'd0);
        tick();
        check_all("t5.done", 0, 2'd0, 0, 1, 24'd2, 0, 0);

        // 6: start while busy is ignored; reset mid-FLASH clears outputs at once.
        tick();
        do_start(2'd3);
        do_start(2'd1);
        check_all("t6.ignored", 0, 2'd3, 1, 0, 24'd2, 0, 0);
        pulse_vsync();
        do_start(2'd2);
        check_all("t6.flash", 1, 2'd3, 1, 0, 24'd2, 0, 0);
        repeat (50) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check_all("t6.async_rst", 0, 2'd0, 0, 0, 24'd0, 0, 0);
        tick();
        #2;
        reset_n = 1'b1;
        tick();
        check_all("t6.post_rst", 0, 2'd0, 0, 0, 24'd0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
